uart_tx: RTL and testbench

- Serial UART transmitter; drains the transmit-side byte buffer and drives the TX line.
- Frame format: start bit, D_BITS data bits LSB first, optional parity, then stop bit(s).
- Internal 16x oversampling tick generator; bit timing derived from the system clock.
- Sits directly downstream of the TX FIFO. The FIFO's not-empty status drives tx_start. The FIFO read strobe is asserted in the accept cycle.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx.sv | 152 +++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and oversampling ratio.
// Used by the transmitter, the baud generator and the future receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Unused upper bits are zero, so they do not disturb the XOR reduction.
    function automatic logic calc_parity(input int mode, input logic [7:0] data);
        logic p;
        p = 1'b0;
        if (mode == PAR_EVEN) begin
            p = ^data;
        end else if (mode == PAR_ODD) begin
            p = ~(^data);
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: s_tick pulses one clock every CLK_DIV clocks; clr holds the count at 0.
// No latency beyond the counter register; no flow control. pre_tick marks the clock before s_tick (CLK_DIV >= 2).
module uart_baud_gen #(
    parameter int CLK_DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick,
    output logic pre_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == W'(CLK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign s_tick   = (cnt == W'(CLK_DIV - 1));
    assign pre_tick = (cnt == W'(CLK_DIV - 2));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, D_BITS data LSB first, optional parity, SB_TICKS/16 stop bits; tx is registered.
// Accepts din when tx_start & tx_ready; holds tx_ready low for the whole frame, upstream holds its request.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D_BITS   = 8,
    parameter int SB_TICKS = 16,
    parameter int PARITY   = 0,
    parameter int CLK_DIV  = 54
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [D_BITS-1:0] din,
    output logic              tx_ready,
    output logic              tx_done_tick,
    output logic              tx
);

    localparam int SMAX = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (D_BITS > 1) ? $clog2(D_BITS) : 1;

    uart_state_t       state_q, state_d;
    logic [SW-1:0]     s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_q, n_d;
    logic [D_BITS-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              s_tick;
    logic              pre_tick;
    logic              baud_clr;

    // Divider runs only while a frame is in flight so the start bit is exactly 16 ticks.
    assign baud_clr = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clr     (baud_clr),
        .s_tick  (s_tick),
        .pre_tick(pre_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                    n_d     = '0;
                    shift_d = din;
                    par_d   = calc_parity(PARITY, 8'(din));
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        state_d = ST_DATA;
                        s_cnt_d = '0;
                        n_d     = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_d = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == NW'(D_BITS - 1)) begin
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        state_d = ST_STOP;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                // Registered done must rise one clock early to land in the final stop clock.
                done_d = (s_cnt_q == SW'(SB_TICKS - 1)) && pre_tick;
                if (s_tick) begin
                    if (s_cnt_q == SW'(SB_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_ready     = (state_q == ST_IDLE);
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Four transmitter instances (8N1, 8E1, 8O1, 8N2) at CLK_DIV=4 checked against queued expected frames.
module tb_uart_tx;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk;
    logic       reset;
    logic [3:0] start_v;
    logic [7:0] din_v [4];
    logic [3:0] rdy_w;
    logic [3:0] done_w;
    logic [3:0] tx_w;

    int n_vec;
    int n_err;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [15:0] bits;
        int         nbits;
        int         stop;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .D_BITS  (8),
            .SB_TICKS((g == 3) ? 32 : 16),
            .PARITY  ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .CLK_DIV (DIV)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .tx_start    (start_v[g]),
            .din         (din_v[g]),
            .tx_ready    (rdy_w[g]),
            .tx_done_tick(done_w[g]),
            .tx          (tx_w[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t make_exp(input int s, input logic [7:0] d);
        exp_t e;
        e.sel   = s;
        e.data  = d;
        e.bits  = '0;
        e.nbits = 9;
        e.stop  = (s == 3) ? 2 * BIT : BIT;
        for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
        if (s == 1) begin
            e.bits[9] = d[0]^d[1]^d[2]^d[3]^d[4]^d[5]^d[6]^d[7];
            e.nbits   = 10;
        end else if (s == 2) begin
            e.bits[9] = ~(d[0]^d[1]^d[2]^d[3]^d[4]^d[5]^d[6]^d[7]);
            e.nbits   = 10;
        end
        return e;
    endfunction

    // Called at a negedge: raise the request; the next posedge is the accept edge.
    task automatic send(input int s, input logic [7:0] d);
        check_val("rdy_pre", {31'd0, rdy_w[s]}, 32'd1);
        start_v[s] = 1'b1;
        din_v[s]   = d;
        exp_q.push_back(make_exp(s, d));
    endtask

    // Walks the frame clock by clock after the accept edge; returns at the negedge of clock last+1.
    task automatic check_frame(input bit keep_start, input logic [7:0] next_d);
        exp_t       e;
        int         last, idx, pos, dn_cnt, dn_at;
        logic       t, exp_tx;
        logic [7:0] got;
        check_val("sb_depth", exp_q.size(), 32'd1);
        if (exp_q.size() == 0) return;
        e      = exp_q.pop_front();
        last   = e.nbits * BIT + e.stop;
        dn_cnt = 0;
        dn_at  = -1;
        got    = '0;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            t = tx_w[e.sel];
            if (done_w[e.sel]) begin
                dn_cnt++;
                dn_at = c;
            end
            if (c <= last) begin
                idx    = (c - 1) / BIT;
                pos    = (c - 1) % BIT;
                exp_tx = (idx < e.nbits) ? e.bits[idx] : 1'b1;
                if (pos == 0 || pos == BIT - 1)
                    check_val($sformatf("tx_s%0d_c%0d", e.sel, c), {31'd0, t}, {31'd0, exp_tx});
                if (idx >= 1 && idx <= 8 && pos == BIT / 2)
                    got[idx-1] = t;
            end
            if (c == 1 || c == last)
                check_val("rdy_busy", {31'd0, rdy_w[e.sel]}, 32'd0);
            if (c == last + 1) begin
                check_val("rdy_idle", {31'd0, rdy_w[e.sel]}, 32'd1);
                check_val("tx_idle", {31'd0, t}, 32'd1);
            end
            if (c == 1) begin
                start_v[e.sel] = keep_start;
                din_v[e.sel]   = next_d;
            end
        end
        check_val("byte", {24'd0, got}, {24'd0, e.data});
        check_val("done_cnt", dn_cnt, 32'd1);
        check_val("done_at", dn_at, last);
    endtask

    initial begin
        int lows, dns;
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        start_v = 4'hF;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h5A;

        // Reset held two clocks with requests pending: nothing may be accepted.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check_val("rst_tx", {31'd0, tx_w[i]}, 32'd1);
                check_val("rst_rdy", {31'd0, rdy_w[i]}, 32'd1);
                check_val("rst_done", {31'd0, done_w[i]}, 32'd0);
            end
        end
        start_v = 4'h0;
        reset   = 1'b0;
        @(negedge clk);

        send(0, 8'h55); check_frame(1'b0, 8'hAA);
        send(1, 8'h07); check_frame(1'b0, 8'hF0);
        send(2, 8'h07); check_frame(1'b0, 8'hF0);
        send(1, 8'hFF); check_frame(1'b0, 8'h00);
        send(2, 8'h00); check_frame(1'b0, 8'hFF);
        send(3, 8'h81); check_frame(1'b0, 8'h7E);

        // Back-to-back with the request held high across the ready cycle.
        send(0, 8'hA5);
        check_frame(1'b1, 8'h3C);
        exp_q.push_back(make_exp(0, 8'h3C));
        check_frame(1'b0, 8'hEE);

        // Abort a frame with reset at clock 300 (data bit 3 of 0x00 is on the line).
        start_v[0] = 1'b1;
        din_v[0]   = 8'h00;
        for (int c = 1; c <= 301; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_v[0] = 1'b0;
                din_v[0]   = 8'hFF;
            end
            if (c == 300) begin
                check_val("abort_pre_tx", {31'd0, tx_w[0]}, 32'd0);
                reset = 1'b1;
            end
            if (c == 301) begin
                check_val("abort_tx", {31'd0, tx_w[0]}, 32'd1);
                check_val("abort_rdy", {31'd0, rdy_w[0]}, 32'd1);
                check_val("abort_done", {31'd0, done_w[0]}, 32'd0);
                reset = 1'b0;
            end
        end
        lows = 0;
        dns  = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (!tx_w[0]) lows++;
            if (done_w[0]) dns++;
        end
        check_val("abort_tx_low", lows, 32'd0);
        check_val("abort_done_cnt", dns, 32'd0);
        send(0, 8'hC3); check_frame(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
